// File: rtl/bcd_clock_counter.sv
// Time-of-day counter (24 h, packed BCD) advanced by rising edges of a 1 Hz tick.
// Optional alarm comparator is compiled in when the ALARM_EN macro is defined.
module bcd_clock_counter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       iCLK,
  input  logic       iRESET,
  input  logic       iTICK,
  input  logic       iRUN,
  input  logic       iLOAD,
  input  logic [7:0] iLOAD_HH,
  input  logic [7:0] iLOAD_MM,
  input  logic [7:0] iLOAD_SS,
`ifdef ALARM_EN
  input  logic       iALM_SET,
  input  logic [7:0] iALM_HH,
  input  logic [7:0] iALM_MM,
  input  logic       iALARM_CLR,
  output logic       oALARM,
`endif
  output logic [7:0] oHH,
  output logic [7:0] oMM,
  output logic [7:0] oSS,
  output logic       oSEC_PULSE,
  output logic       oLOAD_ERR
);

  // Minutes and seconds share the same legal range 00..59.
  function automatic logic sexValid(input logic [7:0] v);
    return (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
  endfunction

  function automatic logic hoursValid(input logic [7:0] v);
    return (v[3:0] <= 4'd9) &&
           ((v[7:4] < 4'd2) || ((v[7:4] == 4'd2) && (v[3:0] <= 4'd3)));
  endfunction

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;
  logic                   tickEdge;

  logic [3:0] ss1_q, ss10_q, mm1_q, mm10_q, hh1_q, hh10_q;
  logic [3:0] ss1_d, ss10_d, mm1_d, mm10_d, hh1_d, hh10_d;
  logic       secPulse_q, secPulse_d;
  logic       loadErr_q, loadErr_d;
  logic       advance;
  logic       loadValid;
  logic       almErr;

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], iTICK};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign tickEdge  = sync_q[SYNC_STAGES-1] & ~dly_q;
  assign advance   = tickEdge & iRUN & ~iLOAD;
  assign loadValid = hoursValid(iLOAD_HH) & sexValid(iLOAD_MM) & sexValid(iLOAD_SS);

  // A load always takes priority and swallows any tick detected in the same cycle.
  always_comb begin
    ss1_d      = ss1_q;
    ss10_d     = ss10_q;
    mm1_d      = mm1_q;
    mm10_d     = mm10_q;
    hh1_d      = hh1_q;
    hh10_d     = hh10_q;
    secPulse_d = 1'b0;
    loadErr_d  = almErr;
    if (iLOAD) begin
      if (loadValid) begin
        {hh10_d, hh1_d} = iLOAD_HH;
        {mm10_d, mm1_d} = iLOAD_MM;
        {ss10_d, ss1_d} = iLOAD_SS;
      end else begin
        loadErr_d = 1'b1;
      end
    end else if (advance) begin
      secPulse_d = 1'b1;
      if (ss1_q != 4'd9) begin
        ss1_d = ss1_q + 4'd1;
      end else begin
        ss1_d = 4'd0;
        if (ss10_q != 4'd5) begin
          ss10_d = ss10_q + 4'd1;
        end else begin
          ss10_d = 4'd0;
          if (mm1_q != 4'd9) begin
            mm1_d = mm1_q + 4'd1;
          end else begin
            mm1_d = 4'd0;
            if (mm10_q != 4'd5) begin
              mm10_d = mm10_q + 4'd1;
            end else begin
              mm10_d = 4'd0;
              if ((hh10_q == 4'd2) && (hh1_q == 4'd3)) begin
                hh1_d  = 4'd0;
                hh10_d = 4'd0;
              end else if (hh1_q == 4'd9) begin
                hh1_d  = 4'd0;
                hh10_d = hh10_q + 4'd1;
              end else begin
                hh1_d = hh1_q + 4'd1;
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      ss1_q      <= 4'd0;
      ss10_q     <= 4'd0;
      mm1_q      <= 4'd0;
      mm10_q     <= 4'd0;
      hh1_q      <= 4'd0;
      hh10_q     <= 4'd0;
      secPulse_q <= 1'b0;
      loadErr_q  <= 1'b0;
    end else begin
      ss1_q      <= ss1_d;
      ss10_q     <= ss10_d;
      mm1_q      <= mm1_d;
      mm10_q     <= mm10_d;
      hh1_q      <= hh1_d;
      hh10_q     <= hh10_d;
      secPulse_q <= secPulse_d;
      loadErr_q  <= loadErr_d;
    end
  end

`ifdef ALARM_EN
  logic [7:0] almHh_q, almHh_d;
  logic [7:0] almMm_q, almMm_d;
  logic       alarm_q, alarm_d;
  logic       almValid;
  logic       almHit;

  assign almValid = hoursValid(iALM_HH) & sexValid(iALM_MM);
  assign almErr   = iALM_SET & ~almValid;
  // Only a tick-driven rollover into second 00 can fire the alarm, never a load.
  assign almHit   = advance && ({ss10_d, ss1_d} == 8'h00) &&
                    ({hh10_d, hh1_d} == almHh_q) && ({mm10_d, mm1_d} == almMm_q);

  always_comb begin
    almHh_d = almHh_q;
    almMm_d = almMm_q;
    alarm_d = alarm_q;
    if (iALM_SET && almValid) begin
      almHh_d = iALM_HH;
      almMm_d = iALM_MM;
    end
    if (almHit) begin
      alarm_d = 1'b1;
    end else if (iALARM_CLR) begin
      alarm_d = 1'b0;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      almHh_q <= 8'h00;
      almMm_q <= 8'h00;
      alarm_q <= 1'b0;
    end else begin
      almHh_q <= almHh_d;
      almMm_q <= almMm_d;
      alarm_q <= alarm_d;
    end
  end

  assign oALARM = alarm_q;
`else
  assign almErr = 1'b0;
`endif

  assign oHH        = {hh10_q, hh1_q};
  assign oMM        = {mm10_q, mm1_q};
  assign oSS        = {ss10_q, ss1_q};
  assign oSEC_PULSE = secPulse_q;
  assign oLOAD_ERR  = loadErr_q;

endmodule

// File: tb/tb_bcd_clock_counter.sv
// Directed self-checking bench for bcd_clock_counter; alarm steps build only with ALARM_EN.
module tb_bcd_clock_counter;

  localparam int SYNC_STAGES = 2;

  logic       iCLK;
  logic       iRESET;
  logic       iTICK;
  logic       iRUN;
  logic       iLOAD;
  logic [7:0] iLOAD_HH;
  logic [7:0] iLOAD_MM;
  logic [7:0] iLOAD_SS;
  logic [7:0] oHH;
  logic [7:0] oMM;
  logic [7:0] oSS;
  logic       oSEC_PULSE;
  logic       oLOAD_ERR;
`ifdef ALARM_EN
  logic       iALM_SET;
  logic [7:0] iALM_HH;
  logic [7:0] iALM_MM;
  logic       iALARM_CLR;
  logic       oALARM;
`endif

  int nCompared;
  int nMismatched;

  bcd_clock_counter #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .iCLK       (iCLK),
    .iRESET     (iRESET),
    .iTICK      (iTICK),
    .iRUN       (iRUN),
    .iLOAD      (iLOAD),
    .iLOAD_HH   (iLOAD_HH),
    .iLOAD_MM   (iLOAD_MM),
    .iLOAD_SS   (iLOAD_SS),
`ifdef ALARM_EN
    .iALM_SET   (iALM_SET),
    .iALM_HH    (iALM_HH),
    .iALM_MM    (iALM_MM),
    .iALARM_CLR (iALARM_CLR),
    .oALARM     (oALARM),
`endif
    .oHH        (oHH),
    .oMM        (oMM),
    .oSS        (oSS),
    .oSEC_PULSE (oSEC_PULSE),
    .oLOAD_ERR  (oLOAD_ERR)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nCompared++;
    assert (observed === expected)
    else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkTime(input string tag, input logic [23:0] expected);
    checkOutput(tag, {8'h00, oHH, oMM, oSS}, {8'h00, expected});
  endtask

  // Strobe iLOAD for one cycle; returns on the negedge after the sampling edge.
  task automatic applyStimulus(input logic [7:0] hh, input logic [7:0] mm,
                               input logic [7:0] ss);
    iLOAD    = 1'b1;
    iLOAD_HH = hh;
    iLOAD_MM = mm;
    iLOAD_SS = ss;
    @(negedge iCLK);
    iLOAD = 1'b0;
  endtask

  // One clean tick; pulse must appear exactly SYNC_STAGES edges after sampling.
  task automatic tickOnce(input string tag, input logic expPulse);
    iTICK = 1'b1;
    @(negedge iCLK);
    @(negedge iCLK);
    checkOutput({tag, "_pre"}, {31'd0, oSEC_PULSE}, 32'd0);
    @(negedge iCLK);
    checkOutput({tag, "_pulse"}, {31'd0, oSEC_PULSE}, {31'd0, expPulse});
    @(negedge iCLK);
    checkOutput({tag, "_post"}, {31'd0, oSEC_PULSE}, 32'd0);
    iTICK = 1'b0;
    repeat (3) @(negedge iCLK);
  endtask

  // Load strobe lands in the exact cycle the tick edge is detected.
  task automatic collideLoad(input string tag, input logic [7:0] hh, input logic [7:0] mm,
                             input logic [7:0] ss, input logic expErr,
                             input logic [23:0] expTime);
    iTICK = 1'b1;
    @(negedge iCLK);
    @(negedge iCLK);
    applyStimulus(hh, mm, ss);
    checkTime({tag, "_time"}, expTime);
    checkOutput({tag, "_err"}, {31'd0, oLOAD_ERR}, {31'd0, expErr});
    checkOutput({tag, "_pulse"}, {31'd0, oSEC_PULSE}, 32'd0);
    @(negedge iCLK);
    checkOutput({tag, "_pulse2"}, {31'd0, oSEC_PULSE}, 32'd0);
    checkTime({tag, "_time2"}, expTime);
    iTICK = 1'b0;
    repeat (3) @(negedge iCLK);
  endtask

  // Directed sequence: reset, counting, loads, collisions, run gating, alarm.
  initial begin
    nCompared   = 0;
    nMismatched = 0;
    iRESET   = 1'b1;
    iTICK    = 1'b0;
    iRUN     = 1'b0;
    iLOAD    = 1'b0;
    iLOAD_HH = 8'h00;
    iLOAD_MM = 8'h00;
    iLOAD_SS = 8'h00;
`ifdef ALARM_EN
    iALM_SET   = 1'b0;
    iALM_HH    = 8'h00;
    iALM_MM    = 8'h00;
    iALARM_CLR = 1'b0;
`endif
    repeat (3) @(negedge iCLK);
    checkTime("reset_time", 24'h000000);
    checkOutput("reset_pulse", {31'd0, oSEC_PULSE}, 32'd0);
    checkOutput("reset_err", {31'd0, oLOAD_ERR}, 32'd0);
`ifdef ALARM_EN
    checkOutput("reset_alarm", {31'd0, oALARM}, 32'd0);
`endif
    iRESET = 1'b0;
    iRUN   = 1'b1;
    repeat (2) @(negedge iCLK);

    tickOnce("tick1", 1'b1);
    checkTime("after_tick1", 24'h000001);
    tickOnce("tick2", 1'b1);
    tickOnce("tick3", 1'b1);
    checkTime("after_tick3", 24'h000003);

    applyStimulus(8'h23, 8'h59, 8'h58);
    checkTime("load_235958", 24'h235958);
    checkOutput("load_no_pulse", {31'd0, oSEC_PULSE}, 32'd0);
    checkOutput("load_no_err", {31'd0, oLOAD_ERR}, 32'd0);
    tickOnce("tick_59", 1'b1);
    checkTime("time_235959", 24'h235959);
    tickOnce("tick_wrap", 1'b1);
    checkTime("time_wrap", 24'h000000);

    applyStimulus(8'h19, 8'h59, 8'h59);
    tickOnce("tick_19", 1'b1);
    checkTime("carry_to_20", 24'h200000);
    applyStimulus(8'h09, 8'h59, 8'h59);
    tickOnce("tick_09", 1'b1);
    checkTime("carry_to_10", 24'h100000);
    applyStimulus(8'h12, 8'h34, 8'h09);
    tickOnce("tick_ss9", 1'b1);
    checkTime("carry_ss_tens", 24'h123410);

    applyStimulus(8'h12, 8'h6A, 8'h00);
    checkOutput("bad_mm_err", {31'd0, oLOAD_ERR}, 32'd1);
    checkTime("bad_mm_time", 24'h123410);
    @(negedge iCLK);
    checkOutput("bad_mm_err_clear", {31'd0, oLOAD_ERR}, 32'd0);
    applyStimulus(8'h24, 8'h00, 8'h00);
    checkOutput("bad_hh_err", {31'd0, oLOAD_ERR}, 32'd1);
    checkTime("bad_hh_time", 24'h123410);
    applyStimulus(8'h00, 8'h00, 8'h60);
    checkOutput("bad_ss_err", {31'd0, oLOAD_ERR}, 32'd1);
    checkTime("bad_ss_time", 24'h123410);
    @(negedge iCLK);

    collideLoad("collide_ok", 8'h10, 8'h00, 8'h00, 1'b0, 24'h100000);
    collideLoad("collide_bad", 8'h24, 8'h00, 8'h00, 1'b1, 24'h100000);

    iRUN = 1'b0;
    for (int i = 0; i < 5; i++) tickOnce("frozen", 1'b0);
    checkTime("frozen_time", 24'h100000);
    applyStimulus(8'h05, 8'h06, 8'h07);
    checkTime("load_while_stopped", 24'h050607);
    iTICK = 1'b1;
    repeat (5) @(negedge iCLK);
    iRUN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge iCLK);
      checkOutput("run_high_no_pulse", {31'd0, oSEC_PULSE}, 32'd0);
    end
    checkTime("run_high_no_advance", 24'h050607);
    iTICK = 1'b0;
    repeat (3) @(negedge iCLK);
    tickOnce("tick_resume", 1'b1);
    checkTime("resume_time", 24'h050608);

`ifdef ALARM_EN
    iALM_SET = 1'b1;
    iALM_HH  = 8'h07;
    iALM_MM  = 8'h30;
    @(negedge iCLK);
    iALM_SET = 1'b0;
    checkOutput("alm_set_err", {31'd0, oLOAD_ERR}, 32'd0);
    iALM_SET = 1'b1;
    iALM_HH  = 8'h25;
    @(negedge iCLK);
    iALM_SET = 1'b0;
    checkOutput("alm_bad_err", {31'd0, oLOAD_ERR}, 32'd1);
    applyStimulus(8'h07, 8'h30, 8'h00);
    checkOutput("alm_load_no_fire", {31'd0, oALARM}, 32'd0);
    applyStimulus(8'h07, 8'h29, 8'h59);
    tickOnce("tick_alarm", 1'b1);
    checkTime("alarm_time", 24'h073000);
    checkOutput("alarm_set", {31'd0, oALARM}, 32'd1);
    repeat (3) @(negedge iCLK);
    checkOutput("alarm_hold", {31'd0, oALARM}, 32'd1);
    iALARM_CLR = 1'b1;
    @(negedge iCLK);
    iALARM_CLR = 1'b0;
    checkOutput("alarm_clear", {31'd0, oALARM}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
